// File: rtl/flow_rate_scheduler_pkg.sv
// Shared types and helpers for the token-bucket flow rate scheduler.
package flow_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int CREDIT_FRAC = 8;

    // Index width for n flows; a single flow still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Credit charged for one packet, in Q.8 bytes.
    function automatic logic [31:0] cost_of(input logic [31:0] size, input int overhead);
        return (size + 32'(overhead)) << CREDIT_FRAC;
    endfunction

endpackage

// File: rtl/flow_rate_scheduler_if.sv
// Offer handshake between the scheduler and the command FIFO writer.
interface flow_rate_scheduler_if #(
    parameter int ID_W = 2
);
    logic            sched_valid;
    logic [ID_W-1:0] sched_id;
    logic            sched_ready;

    modport master (output sched_valid, output sched_id, input sched_ready);
    modport slave  (input sched_valid, input sched_id, output sched_ready);
endinterface

// File: rtl/flow_rate_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
    import flow_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW:0] pos;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        any = |req;
        idx = '0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
            if (req[pos[IW-1:0]]) idx = pos[IW-1:0];
        end
    end

endmodule

// File: rtl/flow_rate_scheduler.sv
// Token-bucket rate scheduler offering eligible flow IDs round-robin.
// Optional per-flow grant counters: define FLOW_RATE_SCHEDULER_STATS_EN.
module flow_rate_scheduler
    import flow_sched_pkg::*;
#(
    parameter int N_FLOWS      = 4,
    parameter int INC_WIDTH    = 16,
    parameter int SIZE_WIDTH   = 11,
    parameter int CREDIT_WIDTH = 24,
    parameter int OVERHEAD     = 20,
    parameter int BURST_BYTES  = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_FLOWS-1:0]              cfg_flow_en,
    input  logic [N_FLOWS*INC_WIDTH-1:0]    cfg_inc,
    input  logic [N_FLOWS*SIZE_WIDTH-1:0]   cfg_size,
    flow_rate_scheduler_if.master           sched,
    output logic [N_FLOWS*32-1:0]           stat_grants
);

    localparam int IW = id_width(N_FLOWS);
    localparam logic [CREDIT_WIDTH-1:0] CAP = CREDIT_WIDTH'(BURST_BYTES) << CREDIT_FRAC;

    state_t                  state, state_nxt;
    logic [IW-1:0]           id_q;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           pick_idx;
    logic                    any_elig;
    logic                    load_id;
    logic                    advance;
    logic [N_FLOWS-1:0]      elig;
    logic [N_FLOWS-1:0]      hs;
    logic [CREDIT_WIDTH-1:0] credit [N_FLOWS];
    logic [CREDIT_WIDTH-1:0] cost   [N_FLOWS];

    // Clamp a signed intermediate credit into [0, CAP].
    function automatic logic [CREDIT_WIDTH-1:0] sat_credit(input logic signed [CREDIT_WIDTH+1:0] v);
        if (v < 0) return '0;
        if (v > $signed({2'b00, CAP})) return CAP;
        return v[CREDIT_WIDTH-1:0];
    endfunction

    assign sched.sched_valid = (state == OFFER);
    assign sched.sched_id    = id_q;

    for (genvar g = 0; g < N_FLOWS; g++) begin : g_flow
        logic [CREDIT_WIDTH+1:0] add;
        logic [CREDIT_WIDTH+1:0] sub;

        assign cost[g] = CREDIT_WIDTH'(cost_of(32'(cfg_size[g*SIZE_WIDTH +: SIZE_WIDTH]), OVERHEAD));
        assign elig[g] = cfg_flow_en[g] && (credit[g] >= cost[g]);
        assign hs[g]   = sched.sched_valid && sched.sched_ready && (id_q == IW'(g));
        assign add     = {2'b00, credit[g]} + (CREDIT_WIDTH + 2)'(cfg_inc[g*INC_WIDTH +: INC_WIDTH]);
        assign sub     = hs[g] ? {2'b00, cost[g]} : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)                  credit[g] <= '0;
            else if (!cfg_flow_en[g]) credit[g] <= '0;
            else                      credit[g] <= sat_credit($signed(add - sub));
        end

`ifdef FLOW_RATE_SCHEDULER_STATS_EN
        logic [31:0] grants;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)        grants <= '0;
            else if (hs[g]) grants <= grants + 32'd1;
        end
        assign stat_grants[g*32 +: 32] = grants;
`endif
    end

`ifndef FLOW_RATE_SCHEDULER_STATS_EN
    assign stat_grants = '0;
`endif

    rr_pick #(.N(N_FLOWS)) u_pick (
        .req (elig),
        .ptr (rr_ptr),
        .any (any_elig),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_id   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    load_id   = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (sched.sched_ready) begin
                    advance   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The offered ID stays frozen until the handshake; the pointer moves past it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q   <= '0;
            rr_ptr <= '0;
        end else begin
            if (load_id) id_q <= pick_idx;
            if (advance) rr_ptr <= (id_q == IW'(N_FLOWS - 1)) ? '0 : id_q + IW'(1);
        end
    end

endmodule

// File: tb/tb_flow_rate_scheduler.sv
// Directed bench for flow_rate_scheduler with a cycle-level token-bucket model.
module tb_flow_rate_scheduler;

    localparam int  NF  = 4;
    localparam longint CAPV = 64'd4096 * 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b1;
    logic [NF-1:0] en = '0;
    logic [15:0] inc_a [NF];
    logic [10:0] size_a [NF];
    logic [NF*16-1:0] cfg_inc;
    logic [NF*11-1:0] cfg_size;
    logic [NF*32-1:0] stat_grants;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    longint m_cred [NF];
    int     m_grants [NF];
    bit     m_offer = 0;
    int     m_id = 0;
    int     m_ptr = 0;

    always #5 clk = ~clk;

    flow_rate_scheduler_if #(.ID_W(2)) sif ();
    assign sif.sched_ready = ready;

    always_comb begin
        cfg_inc  = '0;
        cfg_size = '0;
        for (int i = 0; i < NF; i++) begin
            cfg_inc[i*16 +: 16]  = inc_a[i];
            cfg_size[i*11 +: 11] = size_a[i];
        end
    end

    flow_rate_scheduler #(
        .N_FLOWS(4), .INC_WIDTH(16), .SIZE_WIDTH(11),
        .CREDIT_WIDTH(24), .OVERHEAD(20), .BURST_BYTES(4096)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_flow_en(en),
        .cfg_inc    (cfg_inc),
        .cfg_size   (cfg_size),
        .sched      (sif),
        .stat_grants(stat_grants)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Token-bucket model: credit earns inc per cycle, pays size+20 bytes per grant, clamps to [0, cap].
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NF; i++) begin
                m_cred[i]   = 0;
                m_grants[i] = 0;
            end
            m_offer = 0;
            m_id    = 0;
            m_ptr   = 0;
        end else begin
            longint nc [NF];
            bit     el [NF];
            bit     hs, found;
            longint cost;
            hs = m_offer && ready;
            for (int i = 0; i < NF; i++) begin
                cost  = (longint'(size_a[i]) + 20) * 256;
                el[i] = en[i] && (m_cred[i] >= cost);
                if (!en[i]) nc[i] = 0;
                else nc[i] = m_cred[i] + longint'(inc_a[i]) - ((hs && m_id == i) ? cost : 0);
                if (nc[i] < 0)    nc[i] = 0;
                if (nc[i] > CAPV) nc[i] = CAPV;
            end
            if (m_offer) begin
                if (ready) begin
                    m_grants[m_id]++;
                    m_ptr   = (m_id + 1) % NF;
                    m_offer = 0;
                end
            end else begin
                found = 0;
                for (int k = 0; k < NF; k++) begin
                    if (!found && el[(m_ptr + k) % NF]) begin
                        found   = 1;
                        m_id    = (m_ptr + k) % NF;
                        m_offer = 1;
                    end
                end
            end
            for (int i = 0; i < NF; i++) m_cred[i] = nc[i];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(sif.sched_valid), 32'(m_offer));
            check("id", 32'(sif.sched_id), 32'(m_id));
            for (int i = 0; i < NF; i++) begin
                check("credit", 32'(dut.credit[i]), 32'(m_cred[i]));
`ifdef FLOW_RATE_SCHEDULER_STATS_EN
                check("grants", stat_grants[i*32 +: 32], 32'(m_grants[i]));
`else
                check("grants", stat_grants[i*32 +: 32], 32'd0);
`endif
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int n, k, last, cnt;
        bit got, pv;
        int ids [5];
        int at [5];
        int exp_ids [5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < NF; i++) begin
            inc_a[i]  = '0;
            size_a[i] = 11'd64;
        end
        @(posedge clk);
        #2 chk_en = 1;

        // Single flow at 1 B/cycle, 64-byte packets.
        en       = 4'b0001;
        inc_a[0] = 16'd256;
        ready    = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(sif.sched_valid), 32'd0);
        check("rst_id", 32'(sif.sched_id), 32'd0);
        check("rst_grants", stat_grants[31:0], 32'd0);
        do_reset();
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (sif.sched_valid) got = 1;
        end
        if (!got) timeout("t1_first");
        else check("t1_first_valid_cycle", 32'(n), 32'd85);
        for (int g = 0; g < 2; g++) begin
            last = n; pv = 1; got = 0;
            while (!got && n - last < 200) begin
                @(posedge clk); n++;
                @(negedge clk);
                if (sif.sched_valid && !pv) got = 1;
                pv = sif.sched_valid;
            end
            if (!got) timeout("t1_gap");
            else check("t1_grant_gap", 32'(n - last), 32'd84);
        end

        // Four fast flows: strict rotation with one idle cycle between grants.
        en = 4'hF;
        for (int i = 0; i < NF; i++) inc_a[i] = 16'h7FFF;
        do_reset();
        k = 0; n = 0;
        while (k < 5 && n < 100) begin
            @(negedge clk); n++;
            if (sif.sched_valid) begin
                ids[k] = 32'(sif.sched_id);
                at[k]  = n;
                k++;
            end
        end
        if (k < 5) timeout("t2_grants");
        else begin
            for (int i = 0; i < 5; i++) check("t2_id_order", 32'(ids[i]), 32'(exp_ids[i]));
            for (int i = 1; i < 5; i++) check("t2_gap", 32'(at[i] - at[i-1]), 32'd2);
        end

        // Back-pressure during an offer of flow 2.
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk); n++;
            if (sif.sched_valid && sif.sched_id == 2'd2) begin
                ready = 1'b0;
                got   = 1;
            end
        end
        if (!got) timeout("t3_offer2");
        repeat (200) @(negedge clk);
        check("t3_valid_held", 32'(sif.sched_valid), 32'd1);
        check("t3_id_held", 32'(sif.sched_id), 32'd2);
        check("t3_cap0", 32'(dut.credit[0]), 32'd1048576);
        check("t3_cap1", 32'(dut.credit[1]), 32'd1048576);
        check("t3_cap3", 32'(dut.credit[3]), 32'd1048576);
        ready = 1'b1;

        // Disable flow 1 while it is being offered.
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk); n++;
            if (sif.sched_valid && sif.sched_id == 2'd1) begin
                ready = 1'b0;
                en[1] = 1'b0;
                got   = 1;
            end
        end
        if (!got) timeout("t4_offer1");
        @(negedge clk);
        check("t4_valid_kept", 32'(sif.sched_valid), 32'd1);
        check("t4_id_kept", 32'(sif.sched_id), 32'd1);
        check("t4_credit1_zero", 32'(dut.credit[1]), 32'd0);
        repeat (3) @(negedge clk);
        ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_credit1_after", 32'(dut.credit[1]), 32'd0);
        en[1] = 1'b1;

        // Asynchronous reset while an offer is up.
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (sif.sched_valid) got = 1;
        end
        if (!got) timeout("t5_valid");
        #1 rst = 1'b1;
        #1;
        check("t5_valid_async", 32'(sif.sched_valid), 32'd0);
        check("t5_ptr_async", 32'(dut.rr_ptr), 32'd0);
        for (int i = 0; i < NF; i++) check("t5_credit_async", 32'(dut.credit[i]), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // 1000 grants on flow 3 only.
        en = 4'b1000;
        for (int i = 0; i < NF; i++) inc_a[i] = '0;
        inc_a[3] = 16'h7FFF;
        ready    = 1'b1;
        do_reset();
        cnt = 0; n = 0;
        while (cnt < 1000 && n < 5000) begin
            @(negedge clk); n++;
            if (sif.sched_valid) cnt++;
        end
        if (cnt < 1000) timeout("t6_grants");
        @(posedge clk);
        #2 ready = 1'b0;
        @(negedge clk);
`ifdef FLOW_RATE_SCHEDULER_STATS_EN
        check("t6_grants3", stat_grants[3*32 +: 32], 32'd1000);
`else
        check("t6_grants3", stat_grants[3*32 +: 32], 32'd0);
`endif
        check("t6_grants0", stat_grants[31:0], 32'd0);
        check("t6_grants2", stat_grants[2*32 +: 32], 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
